block_emitter: RTL and testbench

- Transmit-side counterpart of the per-sample block controller used by streaming DCT stages.
- Accepts one full block of BLOCK_SIZE samples in parallel and serialises it as one sample per cycle.
- Each emitted sample carries its index and first/last markers; downstream stages can count and frame it without their own controller.
- Ping-pong block storage sustains 1 sample/cycle across block boundaries under valid/ready flow control.

---
 rtl/dct_stream_pkg.sv | 18 +
 rtl/block_emitter_if.sv | 31 +++
 rtl/block_pingpong_buf.sv | 34 +++
 rtl/block_emitter.sv | 117 +++++++++++
 tb/tb_block_emitter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/dct_stream_pkg.sv
// Shared definitions for streaming DCT stages: default geometry, index width
// helper and the sample-field slicing convention for parallel block buses.
package dct_stream_pkg;

   localparam int unsigned DEF_BLOCK_SIZE = 8;
   localparam int unsigned DEF_DATA_W     = 16;

   // Index width for a block of n samples; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Sample k of a parallel block bus lives at [sample_lsb(k, w) +: w].
   function automatic int unsigned sample_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/block_emitter_if.sv
// Block-in / sample-out handshake bundle for block_emitter.
// master = producer/consumer side, slave = the emitter itself.
interface block_emitter_if
   import dct_stream_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
   parameter int unsigned DATA_W     = DEF_DATA_W
);
   localparam int unsigned IDX_W = idx_w(BLOCK_SIZE);

   logic                         in_valid;
   logic                         in_ready;
   logic [BLOCK_SIZE*DATA_W-1:0] in_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_W-1:0]            out_data;
   logic [IDX_W-1:0]             out_idx;
   logic                         out_first;
   logic                         out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_first, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_first, out_last
   );

endinterface

// File: rtl/block_pingpong_buf.sv
// Two-slot block store with write select and a combinational sample read mux
// addressed by (rd_sel, rd_idx).
module block_pingpong_buf
   import dct_stream_pkg::*;
#(
   parameter  int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
   parameter  int unsigned DATA_W     = DEF_DATA_W,
   localparam int unsigned IDX_W      = idx_w(BLOCK_SIZE)
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic                         wr_sel,
   input  logic [BLOCK_SIZE*DATA_W-1:0] wr_data,
   input  logic                         rd_sel,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic [DATA_W-1:0]            rd_data_c
);

   // Slot contents carry no reset; occupancy in the controller qualifies them.
   logic [BLOCK_SIZE*DATA_W-1:0] slot_q [2];

   always_ff @(posedge clk) begin
      if (wr_en) slot_q[wr_sel] <= wr_data;
   end

   // Explicit compare per sample keeps non-power-of-two block sizes in range.
   always_comb begin
      rd_data_c = '0;
      for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
         if (rd_idx == IDX_W'(k)) rd_data_c = slot_q[rd_sel][sample_lsb(k, DATA_W) +: DATA_W];
      end
   end

endmodule

// File: rtl/block_emitter.sv
// Serialises parallel blocks into one indexed, framed sample per cycle using
// ping-pong storage. Optional block counter: define BLOCK_EMITTER_BLKCNT_EN.
module block_emitter
   import dct_stream_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
   parameter int unsigned DATA_W     = DEF_DATA_W
) (
   input  logic            clk,
   input  logic            rst,
   block_emitter_if.slave  bus
`ifdef BLOCK_EMITTER_BLKCNT_EN
   ,
   output logic [15:0]     blk_cnt,
   output logic            blk_busy
`endif
);

   localparam int unsigned      IDX_W    = idx_w(BLOCK_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

   logic [1:0]        cnt_q, cnt_d;
   logic              wr_sel_q, wr_sel_d;
   logic              rd_sel_q, rd_sel_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;

   logic              have_c;
   logic              full_c;
   logic              load_c;
   logic              pop_c;
   logic              at_last_c;
   logic              pop_last_c;
   logic [DATA_W-1:0] rd_data_c;

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= 2'd0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         rd_idx_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // Next-state: loads fill wr_sel, pops walk rd_idx and retire a slot on the last sample.
   always_comb begin
      have_c     = (cnt_q != 2'd0);
      full_c     = (cnt_q == 2'd2);
      load_c     = bus.in_valid && !full_c;
      pop_c      = have_c && bus.out_ready;
      at_last_c  = (rd_idx_q == LAST_IDX);
      pop_last_c = pop_c && at_last_c;

      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      rd_idx_d = rd_idx_q;
      cnt_d    = cnt_q;

      if (load_c) wr_sel_d = ~wr_sel_q;

      if (pop_c) begin
         if (at_last_c) begin
            rd_idx_d = '0;
            rd_sel_d = ~rd_sel_q;
         end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
         end
      end

      // Load and final pop together leave occupancy unchanged.
      case ({load_c, pop_last_c})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   block_pingpong_buf #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .DATA_W     (DATA_W)
   ) u_buf (
      .clk       (clk),
      .wr_en     (load_c),
      .wr_sel    (wr_sel_q),
      .wr_data   (bus.in_data),
      .rd_sel    (rd_sel_q),
      .rd_idx    (rd_idx_q),
      .rd_data_c (rd_data_c)
   );

   // Interface outputs decode registered state only; out_ready never reaches in_ready.
   assign bus.in_ready  = !full_c;
   assign bus.out_valid = have_c;
   assign bus.out_data  = have_c ? rd_data_c : '0;
   assign bus.out_idx   = rd_idx_q;
   assign bus.out_first = have_c && (rd_idx_q == '0);
   assign bus.out_last  = have_c && at_last_c;

`ifdef BLOCK_EMITTER_BLKCNT_EN
   logic [15:0] blk_cnt_q;

   // Completed-block counter, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst)             blk_cnt_q <= 16'd0;
      else if (pop_last_c) blk_cnt_q <= blk_cnt_q + 16'd1;
   end

   assign blk_cnt  = blk_cnt_q;
   assign blk_busy = (rd_idx_q != '0);
`endif

endmodule

// File: tb/tb_block_emitter.sv
// Directed self-checking bench for block_emitter (BLOCK_SIZE=8, DATA_W=12).
module tb_block_emitter;
   import dct_stream_pkg::*;

   localparam int unsigned BS = 8;
   localparam int unsigned DW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   block_emitter_if #(.BLOCK_SIZE(BS), .DATA_W(DW)) bus ();

`ifdef BLOCK_EMITTER_BLKCNT_EN
   logic [15:0] blk_cnt;
   logic        blk_busy;
`endif

   block_emitter #(.BLOCK_SIZE(BS), .DATA_W(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef BLOCK_EMITTER_BLKCNT_EN
      ,
      .blk_cnt  (blk_cnt),
      .blk_busy (blk_busy)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BS*DW-1:0] mk_blk(input logic [DW-1:0] base);
      logic [BS*DW-1:0] v;
      for (int k = 0; k < int'(BS); k++) v[k*DW +: DW] = base + DW'(k);
      return v;
   endfunction

   // Checks one full block streaming out with out_ready held high.
   task automatic expect_block(input string tag, input logic [DW-1:0] base);
      for (int k = 0; k < int'(BS); k++) begin
         chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, "_data"},  32'(bus.out_data),  32'(base + DW'(k)));
         chk({tag, "_idx"},   32'(bus.out_idx),   32'(k));
         chk({tag, "_first"}, 32'(bus.out_first), 32'(k == 0));
         chk({tag, "_last"},  32'(bus.out_last),  32'(k == int'(BS) - 1));
         step();
      end
   endtask

   task automatic load(input logic [DW-1:0] base);
      bus.in_data  = mk_blk(base);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  32'(bus.out_data),  32'd0);
      chk("rst_idx",   32'(bus.out_idx),   32'd0);
      chk("rst_first", 32'(bus.out_first), 32'd0);
      chk("rst_last",  32'(bus.out_last),  32'd0);
      chk("rst_ready", 32'(bus.in_ready),  32'd1);

      // Single block, sample 0 visible the cycle after the load
      bus.out_ready = 1'b1;
      load(12'h001);
      expect_block("single", 12'h001);
      chk("single_end_valid", 32'(bus.out_valid), 32'd0);
      chk("single_end_ready", 32'(bus.in_ready),  32'd1);

      // Back-to-back A, B then C offered while full
      bus.in_data  = mk_blk(12'h100);
      bus.in_valid = 1'b1;
      step();
      for (int c = 0; c < 24; c++) begin
         logic [DW-1:0] exp_d;
         logic          exp_rdy;
         exp_d   = (c < 8) ? DW'(12'h100 + c) : (c < 16) ? DW'(12'h200 + c - 8) : DW'(12'h300 + c - 16);
         exp_rdy = (c == 0) || (c == 8) || (c >= 16);
         chk("b2b_valid", 32'(bus.out_valid), 32'd1);
         chk("b2b_data",  32'(bus.out_data),  32'(exp_d));
         chk("b2b_idx",   32'(bus.out_idx),   32'(c % 8));
         chk("b2b_first", 32'(bus.out_first), 32'(c % 8 == 0));
         chk("b2b_last",  32'(bus.out_last),  32'(c % 8 == 7));
         chk("b2b_ready", 32'(bus.in_ready),  32'(exp_rdy));
         if (c == 0) bus.in_data = mk_blk(12'h200);
         if (c == 1) bus.in_data = mk_blk(12'h300);
         if (c == 9) bus.in_valid = 1'b0;
         step();
      end
      chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

      // Backpressure: out_ready low for three cycles while idx 3 is presented
      load(12'h400);
      for (int c = 0; c < 11; c++) begin
         int exp_i;
         exp_i = (c <= 3) ? c : (c <= 6) ? 3 : c - 3;
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_idx",   32'(bus.out_idx),   32'(exp_i));
         chk("bp_data",  32'(bus.out_data),  32'(12'h400 + exp_i));
         chk("bp_last",  32'(bus.out_last),  32'(exp_i == 7));
         bus.out_ready = !(c >= 3 && c <= 5);
         step();
      end
      bus.out_ready = 1'b1;
      chk("bp_end_valid", 32'(bus.out_valid), 32'd0);

      // Load coinciding with the final pop at occupancy 1
      load(12'h500);
      for (int c = 0; c < 7; c++) begin
         chk("sim_idx", 32'(bus.out_idx), 32'(c));
         step();
      end
      chk("sim_pre_last",  32'(bus.out_last), 32'd1);
      chk("sim_pre_ready", 32'(bus.in_ready), 32'd1);
      load(12'h600);
      chk("sim_post_ready", 32'(bus.in_ready), 32'd1);
      expect_block("sim_next", 12'h600);
      chk("sim_end_valid", 32'(bus.out_valid), 32'd0);

      // Reset at idx 5 with a second block stored
      bus.in_data  = mk_blk(12'h700);
      bus.in_valid = 1'b1;
      step();
      bus.in_data = mk_blk(12'h780);
      step();
      bus.in_valid = 1'b0;
      chk("rmid_full_ready", 32'(bus.in_ready), 32'd0);
      repeat (4) step();
      chk("rmid_idx5",  32'(bus.out_idx),  32'd5);
      chk("rmid_data5", 32'(bus.out_data), 32'h705);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rmid_valid", 32'(bus.out_valid), 32'd0);
      chk("rmid_ready", 32'(bus.in_ready),  32'd1);
      chk("rmid_data",  32'(bus.out_data),  32'd0);
      chk("rmid_idx",   32'(bus.out_idx),   32'd0);
      chk("rmid_last",  32'(bus.out_last),  32'd0);
      step();
      chk("rmid_idle_valid", 32'(bus.out_valid), 32'd0);
      load(12'h0a0);
      expect_block("fresh", 12'h0a0);
      chk("fresh_end_valid", 32'(bus.out_valid), 32'd0);

`ifdef BLOCK_EMITTER_BLKCNT_EN
      chk("blkcnt_one", 32'(blk_cnt), 32'd1);
      load(12'h0b0);
      step();
      chk("blkbusy_mid", 32'(blk_busy), 32'd1);
      repeat (7) step();
      load(12'h0c0);
      repeat (8) step();
      chk("blkcnt_three", 32'(blk_cnt), 32'd3);
      chk("blkbusy_idle", 32'(blk_busy), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
